addr_seq_ctrl: RTL and testbench
================================

ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, meaning systolic array dimension.
REQ-002 SHALL have parameter QUEUE_SIZE, default 4, meaning serial-number offset between adjacent queues.
REQ-003 SHALL have parameter QUEUE_COUNT, default (ARRAY_SIZE+3)/4, meaning number of address queues driven downstream.
REQ-004 SHALL have parameter FEED_LEN, default 98, meaning last serial number of queue 0.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 16, meaning array flush cycles after feeding; legal range 1..255.
REQ-006 SHALL have parameter IDLE_SERIAL, default 127, meaning serial value that forces downstream addresses to ADDR_MAX.
REQ-007 SHALL derive localparam LAST_SERIAL = FEED_LEN + (QUEUE_COUNT-1)*QUEUE_SIZE (102 at defaults); a configuration with LAST_SERIAL > 126 is illegal.
REQ-008 SHALL have port clk, input, 1, rising-edge clock.
REQ-009 SHALL have port srstn, input, 1: one clock; reset is synchronous and active-low.
REQ-010 SHALL have port start, input, 1, request to run a job; sampled only in IDLE.
REQ-011 SHALL have port tile_num, input, 8, number of tiles in the job; sampled with start.
REQ-012 SHALL have port stall, input, 1, freezes serial advance during FEED.
REQ-013 SHALL have port addr_serial_num, output, 7, registered serial number for the address selector.
REQ-014 SHALL have port addr_valid, output, 1, registered; high when addr_serial_num is a new FEED value.
REQ-015 SHALL have port busy, output, 1, registered; high in FEED and DRAIN.
REQ-016 SHALL have port tile_idx, output, 8, registered index of the current tile.
REQ-017 SHALL have port tile_done, output, 1, registered single-cycle pulse per completed tile.
REQ-018 SHALL have port done, output, 1, registered single-cycle pulse per completed job.

Function
REQ-019 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-020 In IDLE, start=1 with tile_num!=0 SHALL latch tile_num, set tile_idx=0, and enter FEED with addr_serial_num=0 on the next cycle.
REQ-021 In IDLE, start=1 with tile_num==0 SHALL enter DONE directly (done pulse, no FEED or tile_done).
REQ-022 start SHALL be ignored outside IDLE; tile_num changes after sampling SHALL have no effect.
REQ-023 In FEED with stall=0, addr_valid SHALL be 1 and addr_serial_num SHALL increment by 1 each cycle.
REQ-024 In FEED with stall=1, addr_serial_num SHALL hold and addr_valid SHALL be 0 in the following cycle.
REQ-025 When addr_serial_num==LAST_SERIAL is presented with stall=0, next state SHALL be DRAIN with addr_serial_num=IDLE_SERIAL.
REQ-026 DRAIN SHALL last exactly DRAIN_CYCLES cycles regardless of stall.
REQ-027 The cycle after the last DRAIN cycle SHALL assert tile_done=1; if tile_idx==latched tile_num-1, state SHALL be DONE; otherwise state SHALL be FEED with tile_idx incremented and addr_serial_num=0.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
REQ-029 Outside FEED, addr_serial_num SHALL equal IDLE_SERIAL and addr_valid SHALL be 0.
REQ-030 Per tile without stalls, FEED SHALL last LAST_SERIAL+1 cycles and FEED+DRAIN SHALL last LAST_SERIAL+1+DRAIN_CYCLES cycles (119 at defaults).

Reset
REQ-031 srstn=0 at a rising edge SHALL, from the next cycle, force IDLE, addr_serial_num=IDLE_SERIAL, addr_valid=0, busy=0, tile_idx=0, tile_done=0, done=0, and clear drain and tile counters, including mid-FEED or mid-DRAIN.
REQ-032 No done or tile_done pulse SHALL be produced for a job aborted by reset.

Verification
REQ-033 Defaults, tile_num=1, start at edge 0, no stall -> serials 0..102 on cycles 1..103, busy through cycle 119, tile_done=done=1 on cycle 120, IDLE on cycle 121.
REQ-034 tile_num=2, no stall -> cycle 120 tile_done=1, tile_idx=1, addr_serial_num=0; done on cycle 239.
REQ-035 tile_num=1, stall=1 for 5 cycles while addr_serial_num=50 -> serial holds at 50 with addr_valid=0, done delayed to cycle 125.
REQ-036 start with tile_num=0 -> done pulse on the next cycle, busy never asserts, addr_valid never asserts.
REQ-037 srstn=0 for one edge while addr_serial_num=70 -> next cycle all outputs at reset values; a new start then restarts from serial 0.
REQ-038 start pulsed during FEED and DRAIN with tile_num=5 -> ignored; job finishes with original tile count.

Source files
------------

// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: sequences address-selector serial numbers through FEED/DRAIN per tile of a job.
module addr_seq_ctrl #(
    parameter int ARRAY_SIZE   = 8,
    parameter int QUEUE_SIZE   = 4,
    parameter int QUEUE_COUNT  = (ARRAY_SIZE + 3) / 4,
    parameter int FEED_LEN     = 98,
    parameter int DRAIN_CYCLES = 16,
    parameter int IDLE_SERIAL  = 127
) (
    input  logic       clk,
    input  logic       srstn,
    input  logic       start,
    input  logic [7:0] tile_num,
    input  logic       stall,
    output logic [6:0] addr_serial_num,
    output logic       addr_valid,
    output logic       busy,
    output logic [7:0] tile_idx,
    output logic       tile_done,
    output logic       done
);
    localparam int LAST_SERIAL = FEED_LEN + (QUEUE_COUNT - 1) * QUEUE_SIZE;
    localparam logic [6:0] LAST_S = 7'(LAST_SERIAL);
    localparam logic [6:0] IDLE_S = 7'(IDLE_SERIAL);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t     state_q;
    logic [6:0] serial_q;
    logic       valid_q, busy_q, tile_done_q, done_q;
    logic [7:0] idx_q, tiles_q, drain_q;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q     <= IDLE;
            serial_q    <= IDLE_S;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= 8'd0;
            tiles_q     <= 8'd0;
            drain_q     <= 8'd0;
            tile_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (tile_num == 8'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= FEED;
                        tiles_q  <= tile_num;
                        idx_q    <= 8'd0;
                        serial_q <= 7'd0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                FEED: if (stall) begin
                    valid_q <= 1'b0;
                end else if (serial_q == LAST_S) begin
                    state_q  <= DRAIN;
                    serial_q <= IDLE_S;
                    valid_q  <= 1'b0;
                    drain_q  <= 8'd0;
                end else begin
                    serial_q <= serial_q + 7'd1;
                    valid_q  <= 1'b1;
                end
                // stall is deliberately ignored while the array flushes
                DRAIN: if (drain_q == DRAIN_LAST) begin
                    tile_done_q <= 1'b1;
                    drain_q     <= 8'd0;
                    if (idx_q == tiles_q - 8'd1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q  <= FEED;
                        idx_q    <= idx_q + 8'd1;
                        serial_q <= 7'd0;
                        valid_q  <= 1'b1;
                    end
                end else begin
                    drain_q <= drain_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_serial_num = serial_q;
    assign addr_valid      = valid_q;
    assign busy            = busy_q;
    assign tile_idx        = idx_q;
    assign tile_done       = tile_done_q;
    assign done            = done_q;
endmodule

// File: tb/tb_addr_seq_ctrl.sv
// tb_addr_seq_ctrl: vector table, directed job sequences and random traffic against a progress-count model.
module tb_addr_seq_ctrl;
    localparam int LAST  = 102;
    localparam int DRAIN = 16;
    localparam int IDLEV = 127;

    logic       clk = 1'b0;
    logic       srstn = 1'b0, start = 1'b0, stall = 1'b0;
    logic [7:0] tile_num = 8'd0;
    logic [6:0] addr_serial_num;
    logic       addr_valid, busy, tile_done, done;
    logic [7:0] tile_idx;

    int checks = 0;
    int errors = 0;

    addr_seq_ctrl dut (
        .clk(clk), .srstn(srstn), .start(start), .tile_num(tile_num), .stall(stall),
        .addr_serial_num(addr_serial_num), .addr_valid(addr_valid), .busy(busy),
        .tile_idx(tile_idx), .tile_done(tile_done), .done(done)
    );

    always #5 clk = ~clk;

    // Model: one progress count per tile; stall freezes it only while it is still a feed position
    bit m_active, m_fresh, m_td, m_dn;
    int m_t, m_tile, m_n;

    task automatic model_step();
        bit was_done;
        if (!srstn) begin
            m_active = 0; m_fresh = 0; m_td = 0; m_dn = 0; m_t = 0; m_tile = 0;
        end else begin
            was_done = m_dn;
            m_td = 0;
            m_dn = 0;
            if (m_active) begin
                if (m_t <= LAST && stall) m_fresh = 0;
                else begin
                    m_t++;
                    m_fresh = 1;
                    if (m_t == LAST + 1 + DRAIN) begin
                        m_td = 1;
                        if (m_tile == m_n - 1) begin m_active = 0; m_dn = 1; end
                        else begin m_tile++; m_t = 0; end
                    end
                end
            end else if (!was_done && start) begin
                if (tile_num == 8'd0) m_dn = 1;
                else begin m_active = 1; m_t = 0; m_tile = 0; m_n = tile_num; m_fresh = 1; end
            end
        end
    endtask

    function automatic int exp_serial();
        return (m_active && m_t <= LAST) ? m_t : IDLEV;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("serial", 32'(addr_serial_num), 32'(exp_serial()));
        chk("valid", 32'(addr_valid), 32'(m_active && m_t <= LAST && m_fresh));
        chk("busy", 32'(busy), 32'(m_active));
        chk("tile_idx", 32'(tile_idx), 32'(m_tile));
        chk("tile_done", 32'(tile_done), 32'(m_td));
        chk("done", 32'(done), 32'(m_dn));
    endtask

    task automatic step(input bit use_model);
        @(posedge clk);
        model_step();
        #1;
        if (use_model) check_model();
    endtask

    task automatic run_job(input logic [7:0] n, input bit do_stall, input bit spam, output int done_cyc);
        int cyc, stalls;
        tile_num = n; start = 1'b1; stall = 1'b0;
        step(1);
        start = 1'b0;
        cyc = 1;
        stalls = 0;
        while (done !== 1'b1 && cyc < 600) begin
            stall = do_stall && exp_serial() == 50 && stalls < 5;
            if (stall) stalls++;
            start = spam && (cyc % 29 == 0);
            tile_num = spam ? 8'd5 : n;
            step(1);
            cyc++;
        end
        stall = 1'b0; start = 1'b0;
        done_cyc = (done === 1'b1) ? cyc : -1;
    endtask

    typedef struct {
        logic rn, st; logic [7:0] tn; logic sl;
        int ser; logic v, b; int idx; logic td, dn;
    } vec_t;

    vec_t tbl[10];
    int   dc;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 8'd0, 1'b0, 127, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'd0, 1'b0, 127, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 8'd3, 1'b0, 127, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'd3, 1'b0, 0,   1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'd9, 1'b0, 1,   1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'd0, 1'b1, 1,   1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'd0, 1'b0, 2,   1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'd3, 1'b0, 127, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 8'd2, 1'b0, 0,   1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 8'd0, 1'b0, 1,   1'b1, 1'b1, 0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            srstn = tbl[i].rn; start = tbl[i].st; tile_num = tbl[i].tn; stall = tbl[i].sl;
            step(0);
            chk("tbl_serial", 32'(addr_serial_num), 32'(tbl[i].ser));
            chk("tbl_valid", 32'(addr_valid), 32'(tbl[i].v));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].b));
            chk("tbl_idx", 32'(tile_idx), 32'(tbl[i].idx));
            chk("tbl_tdone", 32'(tile_done), 32'(tbl[i].td));
            chk("tbl_done", 32'(done), 32'(tbl[i].dn));
        end
        srstn = 1'b0; start = 1'b0; stall = 1'b0;
        step(1);
        srstn = 1'b1;
        step(1);

        run_job(8'd1, 0, 0, dc);  chk("one_tile_done_cyc", 32'(dc), 32'd120);
        step(1);                  chk("one_tile_idle_busy", 32'(busy), 32'd0);
        run_job(8'd2, 0, 0, dc);  chk("two_tile_done_cyc", 32'(dc), 32'd239);
        step(1);
        run_job(8'd1, 1, 0, dc);  chk("stall_done_cyc", 32'(dc), 32'd125);
        step(1);
        run_job(8'd0, 0, 0, dc);  chk("zero_done_cyc", 32'(dc), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_tdone", 32'(tile_done), 32'd0);
        step(1);
        run_job(8'd2, 0, 1, dc);  chk("spam_done_cyc", 32'(dc), 32'd239);
        step(1);

        tile_num = 8'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 200 && exp_serial() != 70; i++) step(1);
        chk("abort_serial70", 32'(addr_serial_num), 32'd70);
        srstn = 1'b0;
        step(1);
        srstn = 1'b1;
        chk("abort_serial", 32'(addr_serial_num), 32'd127);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(addr_valid), 32'd0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("restart_serial", 32'(addr_serial_num), 32'd0);
        chk("restart_valid", 32'(addr_valid), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            srstn    = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 9) == 0);
            tile_num = 8'($urandom_range(0, 3));
            stall    = ($urandom_range(0, 3) == 0);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
